// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use interlock unit between ID and EX, tracking DEPTH stages.
// Define FWD_STALL_CNT_EN to add the stall_count stall-cycle counter port.
module fwd_hazard_unit #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 2,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic [DATA_W-1:0]       id_rs_data,
    input  logic [DATA_W-1:0]       id_rt_data,
    input  logic                    id_regwrite,
    input  logic [4:0]              id_dst,
    input  logic [LAT_W-1:0]        id_lat,
    input  logic                    flush,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]       src1_data,
    output logic [DATA_W-1:0]       src2_data,
    output logic [SEL_W-1:0]        fwd_sel1,
    output logic [SEL_W-1:0]        fwd_sel2,
    output logic                    stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]             stall_count
`endif
);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][4:0]       dst_q;
    logic [DEPTH-1:0][LAT_W-1:0] cnt_q;

    logic busy1;
    logic busy2;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_sel1  = '0;
        fwd_sel2  = '0;
        src1_data = id_rs_data;
        src2_data = id_rt_data;
        busy1     = 1'b0;
        busy2     = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_q[k] && dst_q[k] == id_rs && id_rs != 5'd0) begin
                fwd_sel1  = SEL_W'(k + 1);
                src1_data = stage_data[k*DATA_W +: DATA_W];
                busy1     = (cnt_q[k] != '0);
            end
            if (v_q[k] && dst_q[k] == id_rt && id_rt != 5'd0) begin
                fwd_sel2  = SEL_W'(k + 1);
                src2_data = stage_data[k*DATA_W +: DATA_W];
                busy2     = (cnt_q[k] != '0);
            end
        end
        stall = id_valid & (busy1 | busy2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q[0]   <= id_valid & id_regwrite & ~stall & ~flush;
            dst_q[0] <= id_dst;
            cnt_q[0] <= id_lat;
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k]   <= v_q[k-1];
                dst_q[k] <= dst_q[k-1];
                cnt_q[k] <= (cnt_q[k-1] == '0) ? '0
                          : cnt_q[k-1] - LAT_W'(1);
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed test-plan cases plus random traffic
// checked against an age/latency model of in-flight producers.
module tb_fwd_hazard_unit;
    localparam int DEPTH  = 3;
    localparam int DATA_W = 32;
    localparam int LAT_W  = 2;
    localparam int SEL_W  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    id_valid;
    logic [4:0]              id_rs, id_rt, id_dst;
    logic [DATA_W-1:0]       id_rs_data, id_rt_data;
    logic                    id_regwrite;
    logic [LAT_W-1:0]        id_lat;
    logic                    flush;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic [DATA_W-1:0]       src1_data, src2_data;
    logic [SEL_W-1:0]        fwd_sel1, fwd_sel2;
    logic                    stall;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]             stall_count;
`endif

    fwd_hazard_unit #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_regwrite(id_regwrite), .id_dst(id_dst),
        .id_lat(id_lat), .flush(flush),
        .stage_data(stage_data),
        .src1_data(src1_data), .src2_data(src2_data),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall(stall)
`ifdef FWD_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // In-flight record; queue index equals age in cycles since entering EX.
    typedef struct {
        bit         wr;
        logic [4:0] dst;
        int         lat;
    } ent_t;

    ent_t        pipe[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;
    bit          m_stall;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.wr = 0; e.dst = 0; e.lat = 0;
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
        exp_cnt = 0;
    endtask

    // Youngest writer of r wins; its value is ready once age >= latency.
    task automatic model_src(input logic [4:0] r, input logic [31:0] rf,
                             output int sel, output logic [31:0] d,
                             output bit busy);
        bit found = 0;
        sel = 0; d = rf; busy = 0;
        if (r != 0) begin
            for (int a = 0; a < pipe.size(); a++) begin
                if (!found && pipe[a].wr && pipe[a].dst == r) begin
                    found = 1;
                    sel   = a + 1;
                    d     = stage_data[a*DATA_W +: DATA_W];
                    busy  = (a < pipe[a].lat);
                end
            end
        end
    endtask

    task automatic drive(input bit v, input logic [4:0] rs,
                         input logic [4:0] rt, input bit rw,
                         input logic [4:0] dst, input int lat,
                         input bit fl);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_regwrite = rw;
        id_dst      = dst;
        id_lat      = LAT_W'(lat);
        flush       = fl;
        id_rs_data  = $urandom;
        id_rt_data  = $urandom;
        stage_data  = {$urandom, $urandom, $urandom};
    endtask

    task automatic settle_check();
        int          s1, s2;
        logic [31:0] d1, d2;
        bit          b1, b2;
        #1;
        model_src(id_rs, id_rs_data, s1, d1, b1);
        model_src(id_rt, id_rt_data, s2, d2, b2);
        m_stall = id_valid && (b1 || b2);
        check("sel1", 64'(fwd_sel1), 64'(s1));
        check("sel2", 64'(fwd_sel2), 64'(s2));
        check("src1", 64'(src1_data), 64'(d1));
        check("src2", 64'(src2_data), 64'(d2));
        check("stall", 64'(stall), 64'(m_stall));
`ifdef FWD_STALL_CNT_EN
        check("stall_count", 64'(stall_count), 64'(exp_cnt));
`endif
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        e.wr  = id_valid && id_regwrite && !m_stall && !flush;
        e.dst = id_dst;
        e.lat = int'(id_lat);
        pipe.push_front(e);
        void'(pipe.pop_back());
        if (m_stall) exp_cnt++;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12 rst_n = 1'b1;
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_sel1", 64'(fwd_sel1), 64'd0);
        check("rst_sel2", 64'(fwd_sel2), 64'd0);
        check("rst_src1", 64'(src1_data), 64'(id_rs_data));
`ifdef FWD_STALL_CNT_EN
        check("rst_count", 64'(stall_count), 64'd0);
`endif
        @(posedge clk); #1;

        drive(1, 3, 0, 0, 0, 0, 0); settle_check();
        check("rf_sel1", 64'(fwd_sel1), 64'd0);
        check("rf_src1", 64'(src1_data), 64'(id_rs_data));
        tick();

        drive(1, 0, 0, 1, 5, 0, 0); settle_check(); tick();
        drive(1, 5, 0, 0, 0, 0, 0); settle_check();
        check("alu_sel_ex", 64'(fwd_sel1), 64'd1);
        check("alu_src_ex", 64'(src1_data), 64'(stage_data[31:0]));
        tick();
        drive(1, 5, 0, 0, 0, 0, 0); settle_check();
        check("alu_sel_mem", 64'(fwd_sel1), 64'd2);
        tick();

        drive(1, 0, 0, 1, 8, 1, 0); settle_check(); tick();
        drive(1, 0, 8, 0, 0, 0, 0); settle_check();
        check("ld_stall", 64'(stall), 64'd1);
        tick();
        drive(1, 0, 8, 0, 0, 0, 0); settle_check();
        check("ld_unstall", 64'(stall), 64'd0);
        check("ld_sel2", 64'(fwd_sel2), 64'd2);
        check("ld_src2", 64'(src2_data), 64'(stage_data[63:32]));
`ifdef FWD_STALL_CNT_EN
        check("ld_count", 64'(stall_count), 64'd1);
`endif
        tick();

        drive(1, 0, 0, 1, 4, 0, 0); settle_check(); tick();
        drive(1, 0, 0, 1, 4, 0, 0); settle_check(); tick();
        drive(1, 4, 0, 0, 0, 0, 0); settle_check();
        check("youngest", 64'(fwd_sel1), 64'd1);
        tick();

        drive(1, 0, 0, 1, 0, 0, 0); settle_check(); tick();
        drive(1, 0, 0, 0, 0, 0, 0); settle_check();
        check("r0_sel1", 64'(fwd_sel1), 64'd0);
        check("r0_stall", 64'(stall), 64'd0);
        tick();

        drive(1, 0, 0, 1, 9, 1, 1); settle_check(); tick();
        drive(1, 9, 0, 0, 0, 0, 0); settle_check();
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_sel1", 64'(fwd_sel1), 64'd0);
        tick();

        drive(1, 0, 0, 1, 8, 1, 0); settle_check(); tick();
        drive(1, 0, 8, 0, 0, 0, 0); settle_check();
        check("pre_rst_stall", 64'(stall), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_sel2", 64'(fwd_sel2), 64'd0);
        model_reset();
        id_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        m_stall = 0;
        tick();

        for (int i = 0; i < 500; i++) begin
            int l;
            l = $urandom_range(0, 9);
            l = (l < 5) ? 0 : (l < 8) ? 1 : (l < 9) ? 2 : 3;
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) != 0,
                  5'($urandom_range(0, 7)), l,
                  $urandom_range(0, 7) == 0);
            settle_check();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use interlock unit for the pipelined CPU, sitting between ID and EX. It tracks the destination register and result-latency of every in-flight instruction across `DEPTH` post-ID stages and selects the youngest ready producer for each source operand. When the youngest producer's result is not yet available, it stalls ID and inserts an EX bubble. It generalises the fixed two-stage MEM/WB forward selector to arbitrary depth, multi-cycle producers and flush.

## Interface
- `DEPTH`, default 3: tracked stages after ID; stage 0 = EX, stage 1 = MEM, stage 2 = WB.
- `DATA_W`, default 32: operand width.
- `LAT_W`, default 2: width of the producer latency field.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  5  ID source registers.
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data.
- `id_regwrite`  in  1  ID instruction writes a register.
- `id_dst`  in  5  ID destination register.
- `id_lat`  in  LAT_W  stages after entering EX before the result is valid: 0 = ALU, 1 = load.
- `flush`  in  1  kill the instruction entering EX this cycle (taken branch/jump).
- `stage_data`  in  DEPTH*DATA_W  result bus of each stage; slice k = bits [k*DATA_W +: DATA_W].
- `src1_data`, `src2_data`  out  DATA_W  forwarded operands for rs and rt.
- `fwd_sel1`, `fwd_sel2`  out  $clog2(DEPTH+1)  0 = register file, k+1 = stage k.
- `stall`  out  1  hold PC and IF/ID; EX receives a bubble.
- `stall_count`  out  32  stall-cycle counter; present only with `FWD_STALL_CNT_EN`.

## Operation
- Entry per stage k: `v`, `dst[4:0]`, `cnt[LAT_W-1:0]`. An entry matches source r iff `v && dst == r && r != 0`.
- Per source, among all matching entries, the lowest k (youngest) wins; older matches are ignored.
- Winner with `cnt == 0`: output `stage_data` slice k and `fwd_sel = k+1`.
- Winner with `cnt != 0`: `stall = 1` when `id_valid`; `fwd_sel` and data still report the would-be source; the consumer must ignore them while stalled.
- No match, or r == 0: register-file data, `fwd_sel = 0`.
- `stall` is the OR over both sources and is forced to 0 when `id_valid = 0`.
- Advance every cycle: entry k moves to k+1 with `cnt` decremented, saturating at 0. Entry DEPTH-1 retires.
- New stage-0 entry: `v = id_valid & id_regwrite & ~stall & ~flush`, `dst = id_dst`, `cnt = id_lat`. If `stall` or `flush` is asserted, a bubble (`v = 0`) is loaded instead.
- `flush` affects only the stage-0 load; older entries continue to advance.

## Timing
- Forward outputs and `stall` are combinational from the entry registers and ID/stage inputs; the following edge shifts the entries.
- Load-use with `id_lat = 1`: exactly 1 stall cycle. With `id_lat = L`: L stall cycles when the consumer immediately follows the producer.
- A producer is forwardable for DEPTH-L cycles; it is not visible after retiring from stage DEPTH-1, when the register file holds the value (write-before-read).
- Reset: all `v = 0`, `cnt = 0`. Outputs are then `stall = 0`, `fwd_sel1/2 = 0`, `src*_data = id_*_data`, and `stall_count = 0`.
- Reset asserted mid-stall clears the stall on the same cycle, asynchronously.
- When `stall` and `flush` coincide, a bubble is loaded and `stall` remains combinational.

## Configuration
- `FWD_STALL_CNT_EN` defined:
  - `stall_count` increments by 1 each cycle with `stall = 1`.
  - It wraps at 2^32 and clears on reset.
- `FWD_STALL_CNT_EN` not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then `id_valid = 1`, `id_rs = 3`, no entries -> `fwd_sel1 = 0`, `src1_data = id_rs_data`, `stall = 0`.
- ALU write r5 (`lat = 0`), then consumer `rs = 5`:
  - Next cycle: `fwd_sel1 = 1`, `src1_data = stage_data[31:0]`.
  - One cycle later: `fwd_sel1 = 2`.
- Load r8 (`lat = 1`), then `rt = 8`:
  - `stall = 1` for 1 cycle, then `fwd_sel2 = 2` with MEM data.
  - `stall_count = 1` when `FWD_STALL_CNT_EN` is defined.
- Two writers of r4 back to back, then `rs = 4` -> `fwd_sel1 = 1` (youngest wins), not 2.
- Writer of r0 followed by a reader of r0 -> `fwd_sel1 = 0`, `stall = 0`.
- `flush` asserted with load r9 in ID, next instruction `rs = 9` -> no stall, `fwd_sel1 = 0`.
- Reset mid-stall -> `stall` drops to 0 immediately.
